// File: rtl/tdm_demux_pkg.sv
// rtl/tdm_demux_pkg.sv - shared constants and state encoding for the TDM demultiplexer
package tdm_demux_pkg;

    localparam int NUM_CH = 8;
    localparam int SLOT_W = 3;
    localparam int LOSS_W = 4;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// rtl/tdm_slot_ctr.sv - 3-bit TDM slot counter with increment, load-to-1 and clear
//   clk, rst   : clock, synchronous active-high reset
//   inc_i      : advance slot by one (wraps 7 -> 0)
//   load1_i    : force slot to 1 (current bit was slot 0)
//   clr_i      : force slot to 0
//   slot_o     : current slot index
module tdm_slot_ctr
    import tdm_demux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              load1_i,
    input  logic              clr_i,
    output logic [SLOT_W-1:0] slot_o
);

    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_d;

    always_comb begin
        slot_d = slot_q;
        if (clr_i) begin
            slot_d = '0;
        end else if (load1_i) begin
            slot_d = SLOT_W'(1);
        end else if (inc_i) begin
            slot_d = slot_q + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux8.sv
// rtl/tdm_demux8.sv - 8-channel TDM demultiplexer with slot-0 marker lock and flywheel
//   clk, rst     : clock, synchronous active-high reset
//   en           : sample enable; low holds all state
//   din          : serial data bit for the current slot
//   frame_sync   : marks current din as slot 0
//   q            : last complete frame, q[i] = slot-i bit
//   frame_valid  : one-cycle pulse when q updates
//   sync_err     : one-cycle pulse on marker at nonzero slot while locked
//   locked       : high in LOCK
//   slot         : slot index the next enabled din is written to
module tdm_demux8
    import tdm_demux_pkg::*;
#(
    parameter logic [LOSS_W-1:0] LOSS_LIMIT = 4'd4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              din,
    input  logic              frame_sync,
    output logic [NUM_CH-1:0] q,
    output logic              frame_valid,
    output logic              sync_err,
    output logic              locked,
    output logic [SLOT_W-1:0] slot
);

    state_t             state_q, state_d;
    logic [NUM_CH-2:0]  shadow_q, shadow_d;
    logic [LOSS_W-1:0]  miss_q, miss_d;
    logic [NUM_CH-1:0]  q_q, q_d;
    logic               fv_q, fv_d;
    logic               se_q, se_d;
    logic               inc, load1, clr;
    logic [SLOT_W-1:0]  slot_w;
    logic               miss_ok;

    tdm_slot_ctr u_slot_ctr (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (inc),
        .load1_i (load1),
        .clr_i   (clr),
        .slot_o  (slot_w)
    );

    // One more missed marker is tolerated only while the count stays below the limit.
    assign miss_ok = ({1'b0, miss_q} + 5'd1) < {1'b0, LOSS_LIMIT};

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        miss_d   = miss_q;
        q_d      = q_q;
        fv_d     = 1'b0;
        se_d     = 1'b0;
        inc      = 1'b0;
        load1    = 1'b0;
        clr      = 1'b0;
        if (en) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_d[0] = din;
                        load1       = 1'b1;
                        miss_d      = '0;
                        state_d     = LOCK;
                    end
                end
                LOCK: begin
                    if (frame_sync) begin
                        // Marker restarts the frame; a mid-frame marker also drops the partial frame.
                        se_d        = (slot_w != '0);
                        shadow_d[0] = din;
                        load1       = 1'b1;
                        miss_d      = '0;
                    end else if (slot_w == '0) begin
                        if (miss_ok) begin
                            miss_d      = miss_q + LOSS_W'(1);
                            shadow_d[0] = din;
                            load1       = 1'b1;
                        end else begin
                            state_d = HUNT;
                            miss_d  = '0;
                            clr     = 1'b1;
                        end
                    end else begin
                        inc = 1'b1;
                        for (int i = 1; i < NUM_CH - 1; i++) begin
                            if (slot_w == SLOT_W'(i)) begin
                                shadow_d[i] = din;
                            end
                        end
                        // Slot 7 bit goes straight to the output frame.
                        if (slot_w == SLOT_W'(NUM_CH - 1)) begin
                            q_d  = {din, shadow_q};
                            fv_d = 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HUNT;
            shadow_q <= '0;
            miss_q   <= '0;
            q_q      <= '0;
            fv_q     <= 1'b0;
            se_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            miss_q   <= miss_d;
            q_q      <= q_d;
            fv_q     <= fv_d;
            se_q     <= se_d;
        end
    end

    assign q           = q_q;
    assign frame_valid = fv_q;
    assign sync_err    = se_q;
    assign locked      = (state_q == LOCK);
    assign slot        = slot_w;

endmodule

// File: tb/tb_tdm_demux8.sv
// tb/tb_tdm_demux8.sv - self-checking bench for tdm_demux8
module tb_tdm_demux8;

    localparam int LIMIT = 4;

    logic       clk = 1'b0;
    logic       rst, en, din, frame_sync;
    logic [7:0] q;
    logic       frame_valid, sync_err, locked;
    logic [2:0] slot;

    tdm_demux8 #(.LOSS_LIMIT(4'(LIMIT))) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .din         (din),
        .frame_sync  (frame_sync),
        .q           (q),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .locked      (locked),
        .slot        (slot)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fv_seen = 0;
    int se_seen = 0;
    bit chk_on = 0;

    // Reference model state
    bit       m_lock;
    int       m_slot;
    int       m_miss;
    bit [7:0] m_sh;
    bit [7:0] m_q;
    bit       m_fv;
    bit       m_se;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit e, input bit fs, input bit d);
        m_fv = 0;
        m_se = 0;
        if (r) begin
            m_lock = 0; m_slot = 0; m_miss = 0; m_sh = 0; m_q = 0;
        end else if (e) begin
            if (!m_lock) begin
                if (fs) begin
                    m_sh[0] = d; m_slot = 1; m_miss = 0; m_lock = 1;
                end
            end else if (fs) begin
                m_se = (m_slot != 0);
                m_sh[0] = d; m_slot = 1; m_miss = 0;
            end else if (m_slot == 0) begin
                if (m_miss + 1 < LIMIT) begin
                    m_miss++; m_sh[0] = d; m_slot = 1;
                end else begin
                    m_lock = 0; m_miss = 0;
                end
            end else begin
                m_sh[m_slot] = d;
                if (m_slot == 7) begin
                    m_q = m_sh;
                    m_fv = 1;
                end
                m_slot = (m_slot + 1) % 8;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("q", q, m_q);
            check("frame_valid", frame_valid, m_fv);
            check("sync_err", sync_err, m_se);
            check("locked", locked, m_lock);
            check("slot", slot, m_slot);
            if (frame_valid === 1'b1) fv_seen++;
            if (sync_err === 1'b1) se_seen++;
        end
    end

    task automatic step(input bit r, input bit e, input bit fs, input bit d);
        rst = r; en = e; frame_sync = fs; din = d;
        @(posedge clk);
        model(r, e, fs, d);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit sync);
        for (int i = 0; i < 8; i++) step(0, 1, sync && (i == 0), b[i]);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; en = 0; din = 0; frame_sync = 0;
        step(1, 0, 0, 0);
        chk_on = 1;
        step(1, 0, 0, 0);
        check("rst_q", q, 8'h00);
        check("rst_locked", locked, 1'b0);
        check("rst_slot", slot, 3'd0);
        check("rst_fv", frame_valid, 1'b0);

        // Basic frame 0x4D
        step(0, 1, 1, 1'b1);
        check("t1_locked_after_sync", locked, 1'b1);
        check("t1_slot_after_sync", slot, 3'd1);
        step(0, 1, 0, 0); step(0, 1, 0, 1); step(0, 1, 0, 1);
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 1);
        step(0, 1, 0, 0);
        check("t1_q", q, 8'h4D);
        check("t1_model_q", m_q, 8'h4D);
        check("t1_fv", frame_valid, 1'b1);
        step(0, 0, 0, 0);
        check("t1_fv_drop", frame_valid, 1'b0);

        // Flywheel through missing markers, lose lock at frame 5
        do_reset();
        fv_seen = 0;
        send_frame(8'h11, 1);
        send_frame(8'h22, 0);
        send_frame(8'h33, 0);
        send_frame(8'h44, 0);
        step(0, 1, 0, 1);
        check("t2_lock_lost", locked, 1'b0);
        check("t2_slot_hunt", slot, 3'd0);
        for (int i = 1; i < 8; i++) step(0, 1, 0, 1'(i & 1));
        step(0, 0, 0, 0);
        check("t2_frames_delivered", fv_seen, 4);
        check("t2_q", q, 8'h44);

        // Misalignment at slot 3
        do_reset();
        send_frame(8'h3C, 1);
        step(0, 0, 0, 0);
        fv_seen = 0; se_seen = 0;
        step(0, 1, 0, 1); step(0, 1, 0, 0); step(0, 1, 0, 1);
        step(0, 1, 1, 1'b0);
        check("t3_sync_err", sync_err, 1'b1);
        check("t3_q_hold", q, 8'h3C);
        check("t3_slot_realign", slot, 3'd1);
        for (int i = 1; i < 8; i++) step(0, 1, 0, 1'((8'h96 >> i) & 1));
        check("t3_fv_none_before", fv_seen, 0);
        check("t3_fv", frame_valid, 1'b1);
        check("t3_q", q, 8'h96);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("t3_se_pulses", se_seen, 1);
        check("t3_fv_pulses", fv_seen, 1);

        // en gap between slots 4 and 5 of 0xA5
        do_reset();
        fv_seen = 0;
        for (int i = 0; i < 5; i++) step(0, 1, i == 0, 1'((8'hA5 >> i) & 1));
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1'(i & 1));
            check("t4_slot_frozen", slot, 3'd5);
            check("t4_fv_gap", frame_valid, 1'b0);
        end
        for (int i = 5; i < 8; i++) step(0, 1, 0, 1'((8'hA5 >> i) & 1));
        check("t4_q", q, 8'hA5);
        check("t4_fv", frame_valid, 1'b1);

        // Reset mid-frame at slot 5
        do_reset();
        send_frame(8'h5A, 1);
        for (int i = 0; i < 5; i++) step(0, 1, i == 0, 1'b1);
        check("t5_slot_before_rst", slot, 3'd5);
        step(1, 1, 0, 1);
        check("t5_q", q, 8'h00);
        check("t5_locked", locked, 1'b0);
        check("t5_slot", slot, 3'd0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1);
        check("t5_still_hunt", locked, 1'b0);
        check("t5_slot_hunt", slot, 3'd0);

        // frame_sync ignored while en is low
        step(0, 0, 1, 1);
        check("t6_locked", locked, 1'b0);
        check("t6_slot", slot, 3'd0);
        step(0, 1, 1, 1);
        check("t6_relock", locked, 1'b1);

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
